// File: rtl/cmd_issuer.sv
// Keypad-to-calculator command sequencer: builds signed operands from keys and issues LOAD/ADD/SUB/CLRLD/DISP strobes.
// Optional sticky overflow flag on the error output, enabled by defining CMD_ISSUER_OVF_LATCH_EN.
module cmd_issuer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       ready,
    input  logic       overflow,
    output logic       new_instruction,
    output logic [2:0] instruction,
    output logic [7:0] data,
    output logic       busy,
    output logic [7:0] entry,
    output logic       key_drop,
    output logic       error
);

    typedef enum logic [2:0] {
        OP_CLRLD = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_DISP  = 3'b011,
        OP_LOAD  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    op_t         queue [0:2];
    logic [1:0]  q_len;
    logic [1:0]  q_ptr;
    logic [3:0]  wait_cnt;
    logic [6:0]  mag;
    logic        neg;
    logic [10:0] mag_prod;
    logic [6:0]  mag_sat;
    logic        accept;
    logic        wait_done;
    logic        queue_empty;
    logic        issue_now;
    op_t         cur_op;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        mag_prod = 11'd10 * {4'd0, mag} + {7'd0, key_code};
        mag_sat  = (mag_prod > 11'd127) ? 7'd127 : mag_prod[6:0];
    end

    assign entry       = neg ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    assign accept      = key_valid && !busy;
    assign wait_done   = (wait_cnt == WAIT_LAST);
    assign queue_empty = (q_ptr == q_len);
    assign cur_op      = queue[q_ptr];

    // IDLE with busy set is the launch cycle after a key queued commands.
    assign issue_now = ((state == S_IDLE) && busy) ||
                       ((state == S_WAIT) && wait_done && ready && !queue_empty);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            new_instruction <= 1'b0;
            instruction     <= OP_DISP;
            data            <= 8'd0;
            key_drop        <= 1'b0;
            mag             <= 7'd0;
            neg             <= 1'b0;
            q_len           <= 2'd0;
            q_ptr           <= 2'd0;
            wait_cnt        <= 4'd0;
            // NOTE: the three-entry queue is reset like any register; it is flops, not a RAM.
            for (int i = 0; i < 3; i++) queue[i] <= OP_DISP;
        end else begin
            new_instruction <= 1'b0;
            key_drop        <= key_valid && busy && (key_code != 4'hD);

            if (accept) begin
                case (key_code)
                    4'hA: begin
                        queue[0] <= OP_LOAD;
                        queue[1] <= OP_ADD;
                        queue[2] <= OP_DISP;
                        q_len    <= 2'd3;
                        q_ptr    <= 2'd0;
                        busy     <= 1'b1;
                    end
                    4'hB: begin
                        queue[0] <= OP_LOAD;
                        queue[1] <= OP_SUB;
                        queue[2] <= OP_DISP;
                        q_len    <= 2'd3;
                        q_ptr    <= 2'd0;
                        busy     <= 1'b1;
                    end
                    4'hC: begin
                        queue[0] <= OP_CLRLD;
                        q_len    <= 2'd1;
                        q_ptr    <= 2'd0;
                        busy     <= 1'b1;
                        mag      <= 7'd0;
                        neg      <= 1'b0;
                    end
                    4'hD: ;
                    4'hE: neg <= !neg;
                    4'hF: begin
                        queue[0] <= OP_DISP;
                        q_len    <= 2'd1;
                        q_ptr    <= 2'd0;
                        busy     <= 1'b1;
                    end
                    default: mag <= mag_sat;
                endcase
            end

            case (state)
                S_IDLE: ;
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= 4'd0;
                end
                S_WAIT: begin
                    if (!wait_done) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end else if (ready && queue_empty) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Strobe and operand are registered on entry to ISSUE and then held until the next issue.
            if (issue_now) begin
                state           <= S_ISSUE;
                new_instruction <= 1'b1;
                instruction     <= cur_op;
                q_ptr           <= q_ptr + 2'd1;
                if (cur_op == OP_LOAD) begin
                    data <= entry;
                    mag  <= 7'd0;
                    neg  <= 1'b0;
                end else begin
                    data <= 8'd0;
                end
            end
        end
    end

`ifdef CMD_ISSUER_OVF_LATCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if (accept && (key_code == 4'hC)) begin
            error <= 1'b0;
        end else if ((state == S_WAIT) && overflow &&
                     ((instruction == OP_ADD) || (instruction == OP_SUB))) begin
            error <= 1'b1;
        end
    end
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: directed scenarios plus random key streams against a keypad/calculator model.
module tb_cmd_issuer;

    localparam int S = 4;
    localparam int P = S + 1;
    localparam logic [2:0] I_CLRLD = 3'b000, I_ADD = 3'b001, I_SUB = 3'b010,
                           I_DISP  = 3'b011, I_LOAD = 3'b100;

    logic       clk = 1'b0;
    logic       reset, key_valid, ready;
    logic       overflow = 1'b0;
    logic [3:0] key_code;
    logic       new_instruction, busy, key_drop, error;
    logic [2:0] instruction;
    logic [7:0] data, entry;

    cmd_issuer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .ready(ready), .overflow(overflow), .new_instruction(new_instruction),
        .instruction(instruction), .data(data), .busy(busy), .entry(entry),
        .key_drop(key_drop), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor, hold/double-strobe watch and a small calculator model driving overflow.
    typedef struct {
        int         cyc;
        logic [2:0] instr;
        logic [7:0] data;
        logic [7:0] ent;
    } strobe_t;

    strobe_t           strobe_q[$];
    int                double_strobes = 0;
    int                hold_violations = 0;
    logic              prev_ni = 1'b0;
    bit                have_last = 1'b0;
    logic [2:0]        last_instr;
    logic [7:0]        last_data;
    logic signed [7:0] acc = 8'sd0;
    logic signed [7:0] operand = 8'sd0;

    always @(negedge clk) begin
        strobe_t s;
        int sum;
        if (reset) begin
            prev_ni   = 1'b0;
            have_last = 1'b0;
            acc       = 8'sd0;
            overflow  = 1'b0;
        end else begin
            if (new_instruction) begin
                if (prev_ni) double_strobes++;
                s.cyc = cyc; s.instr = instruction; s.data = data; s.ent = entry;
                strobe_q.push_back(s);
                last_instr = instruction;
                last_data  = data;
                have_last  = 1'b1;
                overflow   = 1'b0;
                case (instruction)
                    I_CLRLD: acc = 8'sd0;
                    I_LOAD:  operand = data;
                    I_ADD, I_SUB: begin
                        sum = (instruction == I_ADD) ? int'(acc) + int'(operand)
                                                     : int'(acc) - int'(operand);
                        overflow = (sum > 127) || (sum < -128);
                        acc = 8'(sum);
                    end
                    default: ;
                endcase
            end else if (have_last && ((instruction !== last_instr) || (data !== last_data))) begin
                hold_violations++;
            end
            prev_ni = new_instruction;
        end
    end

    // Keypad model: operand arithmetic and the command list each key queues.
    int         m_mag = 0;
    bit         m_neg = 1'b0;
    logic [2:0] exp_ops[$];
    logic [7:0] exp_load;

    function automatic logic [7:0] m_entry();
        return m_neg ? 8'(-m_mag) : 8'(m_mag);
    endfunction

    task automatic model_key(input logic [3:0] code);
        exp_ops.delete();
        exp_load = m_entry();
        case (code)
            4'hA, 4'hB: begin
                exp_ops.push_back(I_LOAD);
                exp_ops.push_back((code == 4'hA) ? I_ADD : I_SUB);
                exp_ops.push_back(I_DISP);
                m_mag = 0; m_neg = 1'b0;
            end
            4'hC: begin
                exp_ops.push_back(I_CLRLD);
                exp_load = 8'd0;
                m_mag = 0; m_neg = 1'b0;
            end
            4'hD: ;
            4'hE: m_neg = !m_neg;
            4'hF: exp_ops.push_back(I_DISP);
            default: m_mag = (m_mag * 10 + int'(code) > 127) ? 127 : m_mag * 10 + int'(code);
        endcase
    endtask

    task automatic press(input logic [3:0] code, output int kc);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = code;
        kc        = cyc;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int g = 0;
        while (strobe_q.size() < n && g < 200) begin
            @(posedge clk);
            g++;
        end
        check($sformatf("strobe count %0d", n), strobe_q.size(), n);
    endtask

    task automatic wait_idle(input int exp_cyc);
        int g = 0;
        @(negedge clk);
        while (busy !== 1'b0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("busy fall cycle", cyc, exp_cyc);
    endtask

    task automatic check_sequence(input int kc);
        int n = exp_ops.size();
        wait_strobes(n);
        for (int i = 0; i < n && i < strobe_q.size(); i++) begin
            check($sformatf("strobe%0d instr", i), strobe_q[i].instr, exp_ops[i]);
            check($sformatf("strobe%0d cycle", i), strobe_q[i].cyc, kc + 2 + i * P);
            if (exp_ops[i] == I_LOAD || exp_ops[i] == I_CLRLD)
                check($sformatf("strobe%0d data", i), strobe_q[i].data, exp_load);
            check($sformatf("strobe%0d entry", i), strobe_q[i].ent, m_entry());
        end
        wait_idle(kc + 2 + n * P);
        check("no extra strobe", strobe_q.size(), n);
    endtask

    task automatic do_key(input logic [3:0] code);
        int kc;
        model_key(code);
        strobe_q.delete();
        press(code, kc);
        if (exp_ops.size() == 0) begin
            repeat (2) @(negedge clk);
            check($sformatf("key %h entry", code), entry, m_entry());
            check($sformatf("key %h no strobe", code), strobe_q.size(), 0);
            check($sformatf("key %h busy", code), busy, 1'b0);
        end else begin
            check_sequence(kc);
            check($sformatf("key %h entry after", code), entry, m_entry());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " new_instruction"}, new_instruction, 1'b0);
        check({tag, " instruction"}, instruction, I_DISP);
        check({tag, " data"}, data, 8'd0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " entry"}, entry, 8'd0);
        check({tag, " key_drop"}, key_drop, 1'b0);
        check({tag, " error"}, error, 1'b0);
    endtask

    initial begin
        int kc, pc, rc;
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // 1,2,add: LOAD 0x0C, ADD, DISP five cycles apart
        do_key(4'h1); do_key(4'h2); do_key(4'hA);

        // 5,negate,sub: LOAD 0xFB then SUB then DISP
        do_key(4'h5); do_key(4'hE);
        check("negated entry", entry, 8'hFB);
        do_key(4'hB);

        // 9,9,9 saturates without any strobe
        do_key(4'h9); do_key(4'h9); do_key(4'h9);
        check("saturated entry", entry, 8'h7F);
        do_key(4'hC);

        // ready held low after LOAD stretches WAIT
        do_key(4'h3);
        model_key(4'hA);
        strobe_q.delete();
        press(4'hA, kc);
        wait_strobes(1);
        #1 ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 ready = 1'b1;
        rc = cyc;
        wait_strobes(3);
        check("stall LOAD cycle", strobe_q[0].cyc, kc + 2);
        check("stall LOAD data", strobe_q[0].data, exp_load);
        check("stall ADD instr", strobe_q[1].instr, I_ADD);
        check("stall ADD cycle", strobe_q[1].cyc, rc + 1);
        check("stall DISP cycle", strobe_q[2].cyc, rc + 1 + P);
        wait_idle(rc + 1 + 2 * P);

        // key during WAIT is dropped and the sequence runs unchanged
        do_key(4'h4);
        model_key(4'hA);
        strobe_q.delete();
        press(4'hA, kc);
        wait_strobes(1);
        press(4'h7, pc);
        check("drop pulse", key_drop, 1'b1);
        @(posedge clk); #1;
        check("drop pulse width", key_drop, 1'b0);
        check("entry kept on drop", entry, m_entry());
        check_sequence(kc);

        // key in the last busy cycle is dropped too
        do_key(4'h2);
        model_key(4'hF);
        strobe_q.delete();
        press(4'hF, kc);
        wait_strobes(1);
        repeat (P - 3) @(posedge clk);
        press(4'h6, pc);
        check("edge drop pulse", key_drop, 1'b1);
        check("edge busy low", busy, 1'b0);
        check("edge entry kept", entry, m_entry());
        repeat (10) @(posedge clk);
        check("edge no strobe", strobe_q.size(), 1);

        // reset asserted during WAIT aborts the sequence
        model_key(4'hA);
        strobe_q.delete();
        press(4'hA, kc);
        wait_strobes(1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async reset");
        @(posedge clk); #1;
        reset = 1'b0;
        m_mag = 0; m_neg = 1'b0;
        strobe_q.delete();
        repeat (30) @(posedge clk);
        check("no strobe after reset", strobe_q.size(), 0);
        check("idle after reset", busy, 1'b0);

`ifdef CMD_ISSUER_OVF_LATCH_EN
        do_key(4'hC);
        do_key(4'h1); do_key(4'h0); do_key(4'h0); do_key(4'hA);
        check("no overflow first add", error, 1'b0);
        do_key(4'h1); do_key(4'h0); do_key(4'h0); do_key(4'hA);
        check("sticky overflow", error, 1'b1);
        do_key(4'hC);
        check("clear resets error", error, 1'b0);
`endif

        // random key stream against the model, ready tied high
        for (int i = 0; i < 40; i++) begin
            logic [3:0] code;
            code = 4'($urandom_range(0, 15));
            do_key(code);
        end

        check("double strobes", double_strobes, 0);
        check("hold violations", hold_violations, 0);
`ifndef CMD_ISSUER_OVF_LATCH_EN
        check("error tied low", error, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, the minimum cycles a command is waited on after issue (legal range 3..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-005 The block SHALL have port key_code, input, 4 bits: key code, where 0x0-0x9 is a digit, 0xA add, 0xB sub, 0xC clear, 0xE negate, 0xF display, and 0xD is ignored.
REQ-006 The block SHALL have port ready, input, 1 bit: calculator ready (high when the calculator controller is idle).
REQ-007 The block SHALL have port overflow, input, 1 bit: calculator ALU overflow.
REQ-008 The block SHALL have port new_instruction, output, 1 bit: command strobe to the calculator.
REQ-009 The block SHALL have port instruction, output, 3 bits: opcode, where CLRLD=000, ADD=001, SUB=010, DISP=011, LOAD=100.
REQ-010 The block SHALL have port data, output, 8 bits: signed two's-complement operand to the calculator.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a command sequence is in progress.
REQ-012 The block SHALL have port entry, output, 8 bits: signed operand currently being keyed.
REQ-013 The block SHALL have port key_drop, output, 1 bit: one-cycle pulse when a key is ignored because the block is busy.
REQ-014 The block SHALL have port error, output, 1 bit: sticky overflow flag (see Configuration).

Function
REQ-015 The issue FSM SHALL have states IDLE, ISSUE and WAIT, plus a sequence pointer over at most 3 queued commands.
REQ-016 In IDLE, an accepted key SHALL be processed in the cycle it is strobed; busy SHALL rise on the next edge when the key queues commands.
REQ-017 The digit key SHALL set mag = min(mag*10 + d, 127), and SHALL NOT queue any command.
REQ-018 The negate key SHALL toggle the sign flag; entry SHALL equal -mag when the sign flag is set and mag otherwise, and the sign flag with mag=0 SHALL give entry=0.
REQ-019 The add and sub keys SHALL queue LOAD(data=entry), then ADD or SUB, then DISP; mag and the sign flag SHALL clear in the cycle the LOAD is issued.
REQ-020 The clear key SHALL queue CLRLD(data=0) and SHALL clear mag and the sign flag immediately.
REQ-021 The display key SHALL queue DISP only; keys 0xD SHALL be ignored without a key_drop pulse.
REQ-022 ISSUE SHALL last exactly 1 cycle, with new_instruction=1 and the instruction and data valid.
REQ-023 new_instruction SHALL never be high for 2 consecutive cycles.
REQ-024 instruction and data SHALL hold their issued values through WAIT and up to the next ISSUE.
REQ-025 WAIT SHALL count SETTLE_CYCLES cycles, then exit when ready=1; if ready=0, WAIT SHALL extend with no timeout.
REQ-026 On WAIT exit, the FSM SHALL go to ISSUE for the next queued command, or to IDLE with busy=0 when the queue is empty.
REQ-027 A key_valid arriving while busy=1 SHALL be dropped with key_drop=1 for 1 cycle, leaving entry unchanged.
REQ-028 When key_valid coincides with the cycle in which busy falls, the key SHALL be dropped (busy is the registered value).
REQ-029 Minimum latency from an add or sub key to the DISP strobe SHALL be 2 + 2*(SETTLE_CYCLES+1) cycles.

Reset
REQ-030 While reset=1, the outputs SHALL be: new_instruction=0, instruction=011, data=0, busy=0, entry=0, key_drop=0 and error=0; the FSM SHALL be in IDLE and the queue SHALL be empty.
REQ-031 A reset asserted mid-sequence SHALL abort the sequence immediately; no further strobe SHALL issue until a new key is accepted after release.

Configuration
REQ-032 With macro CMD_ISSUER_OVF_LATCH_EN defined, error SHALL set on any cycle in which overflow=1 during WAIT after an ADD or SUB, and SHALL clear only on reset or when a clear key is accepted.
REQ-033 Without CMD_ISSUER_OVF_LATCH_EN, error SHALL be constant 0 and overflow SHALL be unused.

Verification
REQ-034 A bench SHALL check that keys 1,2,add (with ready tied 1) -> strobes LOAD data=0x0C, ADD, DISP, each 5 cycles apart, and busy falls after the third WAIT.
REQ-035 A bench SHALL check that keys 5,negate,sub -> LOAD with data=0xFB, then SUB, then DISP, and entry=0 after the LOAD.
REQ-036 A bench SHALL check that keys 9,9,9 -> entry=0x7F (saturated) and no strobe is issued.
REQ-037 A bench SHALL check that ready held 0 for 10 cycles after the LOAD strobe -> WAIT extends, the next strobe comes 1 cycle after ready rises, and new_instruction is never high 2 cycles in a row.
REQ-038 A bench SHALL check that a key during busy -> key_drop is pulsed, entry is unchanged, and the sequence is unaffected; reset asserted during WAIT -> all outputs go to reset values asynchronously and no further strobe is issued.
REQ-039 With CMD_ISSUER_OVF_LATCH_EN defined, a bench SHALL check that 100,add,100,add (calculator model) -> overflow during the second ADD sets error=1, and the clear key clears error and issues CLRLD.
